pipe_stage_reg: RTL and testbench



---
 rtl/pipe_stage_reg_pkg.sv | 23 ++
 rtl/pipe_stage_reg_slot.sv | 36 +++
 rtl/pipe_stage_reg.sv | 166 ++++++++++++++++
 tb/tb_pipe_stage_reg.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_stage_reg_pkg.sv
// Shared types and constants for the elastic pipeline-stage register.
// State encoding, MIPS register-field positions and the slot-width helper.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } pipe_state_e;

    localparam int RS_HI = 25;
    localparam int RS_LO = 21;
    localparam int RT_HI = 20;
    localparam int RT_LO = 16;
    localparam int RD_HI = 15;
    localparam int RD_LO = 11;

    // One slot holds {ctrl, instr, ops}.
    function automatic int slot_w(input int ctrl_w, input int data_w, input int num_ops);
        return ctrl_w + 32 + num_ops * data_w;
    endfunction

endpackage

// File: rtl/pipe_stage_reg_slot.sv
// Width-parametrised storage slot: synchronous load/clear, async active-high reset.
// Clear wins over load so a flush always leaves the slot zeroed.
module pipe_slot #(
    parameter int W = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         load,
    input  logic         clear,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] data_q;
    logic [W-1:0] data_d;

    always_comb begin
        data_d = data_q;
        if (clear) begin
            data_d = '0;
        end else if (load) begin
            data_d = d;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign q = data_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Elastic pipeline-stage register with a one-entry skid slot and flush.
// Optional saturating stall counter enabled by defining PIPE_STALL_CNT_EN.
//
// Handshake: a transfer happens on a rising edge where valid && ready. in_ready
// is decoded from the registered state only, so out_ready never reaches it.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int CTRL_W  = 9,
    parameter int DATA_W  = 32,
    parameter int NUM_OPS = 3,
    parameter int CNT_W   = 16
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [CTRL_W-1:0]         in_ctrl,
    input  logic [31:0]               in_instr,
    input  logic [NUM_OPS*DATA_W-1:0] in_ops,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [CTRL_W-1:0]         out_ctrl,
    output logic [31:0]               out_instr,
    output logic [NUM_OPS*DATA_W-1:0] out_ops,
    output logic [4:0]                out_rs,
    output logic [4:0]                out_rt,
    output logic [4:0]                out_rd,
`ifdef PIPE_STALL_CNT_EN
    output logic [CNT_W-1:0]          stall_cnt,
`endif
    output logic [1:0]                dbg_state
);

    localparam int OPS_W  = NUM_OPS * DATA_W;
    localparam int SLOT_W = slot_w(CTRL_W, DATA_W, NUM_OPS);

    pipe_state_e state_q;
    pipe_state_e state_d;

    logic              main_load;
    logic              main_clr;
    logic              skid_load;
    logic              skid_clr;
    logic [SLOT_W-1:0] in_bundle;
    logic [SLOT_W-1:0] main_din;
    logic [SLOT_W-1:0] main_q;
    logic [SLOT_W-1:0] skid_q;
    logic              accept;
    logic              pop;

    assign in_bundle = {in_ctrl, in_instr, in_ops};
    assign in_ready  = (state_q != FULL);
    assign out_valid = (state_q != EMPTY);
    assign accept    = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign dbg_state = state_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        main_load = 1'b0;
        main_clr  = 1'b0;
        skid_load = 1'b0;
        skid_clr  = 1'b0;
        main_din  = in_bundle;
        if (flush) begin
            // A same-cycle pop has already been seen downstream; the accept is dropped.
            state_d  = EMPTY;
            main_clr = 1'b1;
            skid_clr = 1'b1;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        main_load = 1'b1;
                        state_d   = BUSY;
                    end
                end
                BUSY: begin
                    if (accept && pop) begin
                        main_load = 1'b1;
                    end else if (accept) begin
                        skid_load = 1'b1;
                        state_d   = FULL;
                    end else if (pop) begin
                        main_clr  = 1'b1;
                        state_d   = EMPTY;
                    end
                end
                FULL: begin
                    if (pop) begin
                        main_din  = skid_q;
                        main_load = 1'b1;
                        skid_clr  = 1'b1;
                        state_d   = BUSY;
                    end
                end
                default: begin
                    state_d  = EMPTY;
                    main_clr = 1'b1;
                    skid_clr = 1'b1;
                end
            endcase
        end
    end

    pipe_slot #(.W(SLOT_W)) u_main (
        .clock (clock),
        .reset (reset),
        .load  (main_load),
        .clear (main_clr),
        .d     (main_din),
        .q     (main_q)
    );

    pipe_slot #(.W(SLOT_W)) u_skid (
        .clock (clock),
        .reset (reset),
        .load  (skid_load),
        .clear (skid_clr),
        .d     (in_bundle),
        .q     (skid_q)
    );

    assign out_ctrl  = main_q[SLOT_W-1 -: CTRL_W];
    assign out_instr = main_q[OPS_W +: 32];
    assign out_ops   = main_q[OPS_W-1:0];
    assign out_rs    = out_instr[RS_HI:RS_LO];
    assign out_rt    = out_instr[RT_HI:RT_LO];
    assign out_rd    = out_instr[RD_HI:RD_LO];

`ifdef PIPE_STALL_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] stall_cnt_d;

    // Saturating; deliberately ignores flush so stall history survives a kill.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (out_valid && !out_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`else
    localparam int unused_cnt_w = CNT_W;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: vector table, reset/stream/async-reset sequences,
// a random-handshake scoreboard run, and the stall counter when PIPE_STALL_CNT_EN is set.
module tb_pipe_stage_reg;

    localparam int CTRL_W  = 9;
    localparam int DATA_W  = 32;
    localparam int NUM_OPS = 3;
`ifdef PIPE_STALL_CNT_EN
    localparam int CNT_W = 4;
`else
    localparam int CNT_W = 16;
`endif

    logic                      clock = 1'b0;
    logic                      reset = 1'b1;
    logic                      flush = 1'b0;
    logic                      in_valid = 1'b0;
    logic                      in_ready;
    logic [CTRL_W-1:0]         in_ctrl = '0;
    logic [31:0]               in_instr = '0;
    logic [NUM_OPS*DATA_W-1:0] in_ops = '0;
    logic                      out_valid;
    logic                      out_ready = 1'b0;
    logic [CTRL_W-1:0]         out_ctrl;
    logic [31:0]               out_instr;
    logic [NUM_OPS*DATA_W-1:0] out_ops;
    logic [4:0]                out_rs;
    logic [4:0]                out_rt;
    logic [4:0]                out_rd;
    logic [1:0]                dbg_state;
`ifdef PIPE_STALL_CNT_EN
    logic [CNT_W-1:0]          stall_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] exp_q[$];

    pipe_stage_reg #(
        .CTRL_W  (CTRL_W),
        .DATA_W  (DATA_W),
        .NUM_OPS (NUM_OPS),
        .CNT_W   (CNT_W)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ctrl   (in_ctrl),
        .in_instr  (in_instr),
        .in_ops    (in_ops),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ctrl  (out_ctrl),
        .out_instr (out_instr),
        .out_ops   (out_ops),
        .out_rs    (out_rs),
        .out_rt    (out_rt),
        .out_rd    (out_rd),
`ifdef PIPE_STALL_CNT_EN
        .stall_cnt (stall_cnt),
`endif
        .dbg_state (dbg_state)
    );

    // Clock
    always #5 clock = ~clock;

    // Payload model: ctrl and operands are derived from the instruction word.
    function automatic logic [CTRL_W-1:0] ctrl_of(input logic [31:0] instr);
        return instr[CTRL_W-1:0] | 9'h100;
    endfunction

    function automatic logic [NUM_OPS*DATA_W-1:0] ops_of(input logic [31:0] instr);
        return {~instr, instr ^ 32'h5A5A_5A5A, instr + 32'd1};
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] instr, input logic r, input logic f);
        in_valid  = v;
        in_instr  = instr;
        in_ctrl   = ctrl_of(instr);
        in_ops    = ops_of(instr);
        out_ready = r;
        flush     = f;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic check_bubble(input string tag);
        chk({tag, "_out_valid"}, 128'(out_valid), 128'(1'b0));
        chk({tag, "_out_ctrl"},  128'(out_ctrl),  128'(0));
        chk({tag, "_out_instr"}, 128'(out_instr), 128'(0));
        chk({tag, "_out_ops"},   128'(out_ops),   128'(0));
        chk({tag, "_in_ready"},  128'(in_ready),  128'(1'b1));
    endtask

    // One scoreboarded cycle: inputs driven at negedge, handshakes observed mid-cycle.
    task automatic sb_step(input logic v, input logic [31:0] instr, input logic r, input logic f);
        logic [31:0] exp_instr;
        @(negedge clock);
        drive(v, instr, r, f);
        #1;
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("sb_unexpected_pop", 128'(out_instr), 128'hDEAD);
            end else begin
                exp_instr = exp_q.pop_front();
                chk("sb_pop_instr", 128'(out_instr), 128'(exp_instr));
                chk("sb_pop_ops", 128'(out_ops), 128'(ops_of(exp_instr)));
            end
        end
        if (f) begin
            exp_q.delete();
        end else if (in_valid && in_ready) begin
            exp_q.push_back(instr);
        end
        @(posedge clock);
    endtask

    typedef struct {
        logic        v;
        logic [31:0] instr;
        logic        r;
        logic        f;
        logic        ev;
        logic        er;
        logic [31:0] ei;
    } vec_t;

    vec_t vecs[13];

    initial begin
        // Hand-computed cycle table, starting from EMPTY.
        vecs[0]  = '{1'b1, 32'hA000_0001, 1'b1, 1'b0, 1'b1, 1'b1, 32'hA000_0001};
        vecs[1]  = '{1'b1, 32'hA000_0002, 1'b1, 1'b0, 1'b1, 1'b1, 32'hA000_0002};
        vecs[2]  = '{1'b1, 32'hA000_0003, 1'b0, 1'b0, 1'b1, 1'b0, 32'hA000_0002};
        vecs[3]  = '{1'b1, 32'hA000_0004, 1'b0, 1'b0, 1'b1, 1'b0, 32'hA000_0002};
        vecs[4]  = '{1'b1, 32'hA000_0004, 1'b1, 1'b0, 1'b1, 1'b1, 32'hA000_0003};
        vecs[5]  = '{1'b1, 32'hA000_0004, 1'b0, 1'b0, 1'b1, 1'b0, 32'hA000_0003};
        vecs[6]  = '{1'b1, 32'hA000_0005, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0};
        vecs[7]  = '{1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 1'b1, 32'h0};
        vecs[8]  = '{1'b1, 32'hA000_0006, 1'b0, 1'b0, 1'b1, 1'b1, 32'hA000_0006};
        vecs[9]  = '{1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 1'b1, 32'hA000_0006};
        vecs[10] = '{1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 1'b1, 32'h0};
        vecs[11] = '{1'b1, 32'hA000_0007, 1'b1, 1'b0, 1'b1, 1'b1, 32'hA000_0007};
        vecs[12] = '{1'b1, 32'hA000_0008, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0};

        // Reset with a bundle presented: nothing may be captured.
        drive(1'b1, 32'h012A_4020, 1'b0, 1'b0);
        #12;
        check_bubble("rst");
        chk("rst_rs", 128'(out_rs), 128'(0));
        chk("rst_state", 128'(dbg_state), 128'(2'd0));
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;
        chk("rst_acc_valid", 128'(out_valid), 128'(1'b1));
        chk("rst_acc_rs", 128'(out_rs), 128'(5'd9));
        chk("rst_acc_rt", 128'(out_rt), 128'(5'd10));
        chk("rst_acc_rd", 128'(out_rd), 128'(5'd8));

        // Table-driven vectors.
        do_reset();
        for (int i = 0; i < 13; i++) begin
            @(negedge clock);
            drive(vecs[i].v, vecs[i].instr, vecs[i].r, vecs[i].f);
            @(posedge clock);
            #1;
            chk($sformatf("vec%0d_out_valid", i), 128'(out_valid), 128'(vecs[i].ev));
            chk($sformatf("vec%0d_in_ready", i), 128'(in_ready), 128'(vecs[i].er));
            chk($sformatf("vec%0d_out_instr", i), 128'(out_instr), 128'(vecs[i].ei));
            chk($sformatf("vec%0d_out_ctrl", i), 128'(out_ctrl),
                128'(vecs[i].ev ? ctrl_of(vecs[i].ei) : 9'h0));
            chk($sformatf("vec%0d_out_ops", i), 128'(out_ops),
                128'(vecs[i].ev ? ops_of(vecs[i].ei) : '0));
        end

        // Streaming: one-cycle latency, in_ready never drops.
        do_reset();
        exp_q.delete();
        for (int i = 0; i < 8; i++) begin
            sb_step(1'b1, 32'(i), 1'b1, 1'b0);
            #1;
            chk($sformatf("stream%0d_instr", i), 128'(out_instr), 128'(i));
            chk($sformatf("stream%0d_in_ready", i), 128'(in_ready), 128'(1'b1));
        end
        for (int i = 0; i < 3; i++) sb_step(1'b0, 32'h0, 1'b1, 1'b0);
        chk("stream_drained", 128'(exp_q.size()), 128'(0));

        // Random handshakes with rare flushes against the scoreboard.
        do_reset();
        exp_q.delete();
        for (int i = 0; i < 400; i++) begin
            sb_step(1'($urandom_range(0, 1)), 32'h1000 + 32'(i),
                    1'($urandom_range(0, 1)), ($urandom_range(0, 29) == 0));
        end
        for (int i = 0; i < 4; i++) sb_step(1'b0, 32'h0, 1'b1, 1'b0);
        chk("rand_drained", 128'(exp_q.size()), 128'(0));
        chk("rand_empty_state", 128'(dbg_state), 128'(2'd0));

        // Asynchronous reset while FULL.
        do_reset();
        @(negedge clock);
        drive(1'b1, 32'hB000_0001, 1'b0, 1'b0);
        @(negedge clock);
        drive(1'b1, 32'hB000_0002, 1'b0, 1'b0);
        @(negedge clock);
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        #1;
        chk("full_in_ready", 128'(in_ready), 128'(1'b0));
        chk("full_state", 128'(dbg_state), 128'(2'd2));
        #1 reset = 1'b1;
        #1;
        check_bubble("async_rst");
        chk("async_rst_state", 128'(dbg_state), 128'(2'd0));
        @(negedge clock);
        reset = 1'b0;

`ifdef PIPE_STALL_CNT_EN
        // Saturation and flush immunity of the stall counter.
        do_reset();
        @(negedge clock);
        drive(1'b1, 32'hC000_0001, 1'b0, 1'b0);
        @(negedge clock);
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        repeat (20) @(negedge clock);
        chk("stall_sat", 128'(stall_cnt), 128'(4'hF));
        drive(1'b0, 32'h0, 1'b0, 1'b1);
        @(negedge clock);
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        chk("stall_flush", 128'(stall_cnt), 128'(4'hF));
        chk("stall_flush_valid", 128'(out_valid), 128'(1'b0));
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
